// File: rtl/expr_pipe_unit.sv
// Two-stage lane-parallel expression unit: S1 holds the accepted operands, S2 holds the
// computed result. Each output handshake is folded into a running 32-bit signature.
module expr_pipe_unit #(
    parameter int               W     = 6,
    parameter int               LANES = 6,
    parameter logic [LANES-1:0] SMASK = 6'b111000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [LANES*W-1:0]       a,
    input  logic [LANES*W-1:0]       b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*(W+1)-1:0]   y,
    input  logic                     sig_clr,
    output logic [31:0]              sig
);

    localparam int EW  = W + 1;
    localparam int YW  = LANES * EW;
    localparam int NCH = (YW + 31) / 32;
    localparam int PW  = NCH * 32;

    logic               s1_valid_reg;
    logic [1:0]         s1_op_reg;
    logic [LANES*W-1:0] s1_a_reg;
    logic [LANES*W-1:0] s1_b_reg;
    logic               s2_valid_reg;
    logic [YW-1:0]      y_reg;
    logic [31:0]        sig_reg;

    logic [YW-1:0]      y_next;
    logic [31:0]        fold_next;
    logic [31:0]        sig_next;
    logic [PW-1:0]      y_padded;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;
    logic               out_fire;

    // S1 can only move forward into S2, so both stages advance together.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = s2_adv;
    assign in_ready = rst_n && (!s1_valid_reg || s1_adv);
    assign accept   = in_valid && in_ready;
    assign out_fire = s2_valid_reg && out_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [EW-1:0] ea;
            logic [EW-1:0] eb;
            logic          lt;
            logic [EW-1:0] lane_y;

            if (SMASK[gi]) begin : g_signed
                assign ea = {s1_a_reg[gi*W + W - 1], s1_a_reg[gi*W +: W]};
                assign eb = {s1_b_reg[gi*W + W - 1], s1_b_reg[gi*W +: W]};
                assign lt = $signed(ea) < $signed(eb);
            end else begin : g_unsigned
                assign ea = {1'b0, s1_a_reg[gi*W +: W]};
                assign eb = {1'b0, s1_b_reg[gi*W +: W]};
                assign lt = ea < eb;
            end

            always_comb begin
                lane_y = '0;
                case (s1_op_reg)
                    2'd0:    lane_y = ea + eb;
                    2'd1:    lane_y = ea - eb;
                    2'd2:    lane_y = {{W{1'b0}}, lt};
                    default: lane_y = ea ^ ~eb;
                endcase
            end

            assign y_next[gi*EW +: EW] = lane_y;
        end
    endgenerate

    // Signature input: the result padded to whole 32-bit words, all words XORed together.
    always_comb begin
        y_padded          = '0;
        y_padded[YW-1:0]  = y_reg;
        fold_next         = '0;
        for (int i = 0; i < NCH; i++) begin
            fold_next = fold_next ^ y_padded[i*32 +: 32];
        end
        sig_next = {sig_reg[30:0], sig_reg[31]} ^ fold_next;
    end

    // Operand registers carry no reset: they are only meaningful while s1_valid_reg is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_reg <= op;
            s1_a_reg  <= a;
            s1_b_reg  <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            y_reg        <= '0;
            sig_reg      <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end

            // y only changes when a real beat moves in, never from idle S1 contents.
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    y_reg <= y_next;
                end
            end

            if (sig_clr) begin
                sig_reg <= '0;
            end else if (out_fire) begin
                sig_reg <= sig_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign y         = y_reg;
    assign sig       = sig_reg;

endmodule

// File: tb/tb_expr_pipe_unit.sv
// Directed bench for expr_pipe_unit: expected results are queued when a beat is accepted
// and a negedge monitor pops and compares on every output handshake.
module tb_expr_pipe_unit;

    localparam int W     = 6;
    localparam int LANES = 6;
    localparam int AW    = LANES * W;
    localparam int YW    = LANES * (W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op = 2'd0;
    logic [AW-1:0] a = '0;
    logic [AW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [YW-1:0] y;
    logic          sig_clr = 1'b0;
    logic [31:0]   sig;

    int            checks = 0;
    int            errors = 0;
    int            acc_cnt = 0;
    int            beat_no = 0;
    logic [YW-1:0] exp_q[$];

    always #5 clk = ~clk;

    expr_pipe_unit #(.W(W), .LANES(LANES), .SMASK(6'b111000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sig_clr   (sig_clr),
        .sig       (sig)
    );

    function automatic logic [AW-1:0] p6(input logic [5:0] l5, l4, l3, l2, l1, l0);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [YW-1:0] p7(input logic [6:0] l5, l4, l3, l2, l1, l0);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: any handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beat_no++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%h required=none", y);
            end else begin
                logic [YW-1:0] e;
                e = exp_q.pop_front();
                $display("beat %0d y=%h expected=%h", beat_no, y, e);
                chk("beat_y", {22'b0, y}, {22'b0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted; the expectation is queued on acceptance.
    task automatic send(input logic [1:0] o, input logic [AW-1:0] av, input logic [AW-1:0] bv,
                        input logic [YW-1:0] ev);
        int n;
        n = 0;
        op = o;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (in_ready) begin
            exp_q.push_back(ev);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        tick();
        in_valid = 1'b0;
    endtask

    logic [AW-1:0] v1a, v1b, v2a, v2b, v3a, v3b, v4a, v4b, vsa, vsb;
    logic [YW-1:0] v1y, v2y, v3y, v4y, vsy;
    logic [YW-1:0] y_hold;
    int            acc0;
    int            n;

    initial begin
        v1a = p6(6'h20, 6'h00, 6'h3F, 6'h00, 6'h15, 6'h3F);
        v1b = p6(6'h20, 6'h00, 6'h01, 6'h00, 6'h0A, 6'h01);
        v1y = p7(7'h40, 7'h00, 7'h00, 7'h00, 7'h1F, 7'h40);
        v2a = p6(6'h20, 6'h01, 6'h00, 6'h00, 6'h00, 6'h10);
        v2b = p6(6'h01, 6'h3F, 6'h00, 6'h00, 6'h01, 6'h05);
        v2y = p7(7'h5F, 7'h02, 7'h00, 7'h00, 7'h7F, 7'h0B);
        v3a = p6(6'h20, 6'h3F, 6'h01, 6'h05, 6'h01, 6'h3F);
        v3b = p6(6'h1F, 6'h01, 6'h3F, 6'h05, 6'h3F, 6'h01);
        v3y = p7(7'h01, 7'h01, 7'h00, 7'h00, 7'h01, 7'h00);
        v4a = p6(6'h00, 6'h20, 6'h3F, 6'h3F, 6'h2A, 6'h00);
        v4b = p6(6'h20, 6'h00, 6'h00, 6'h3F, 6'h15, 6'h00);
        v4y = p7(7'h1F, 7'h1F, 7'h00, 7'h7F, 7'h40, 7'h7F);
        vsa = p6(6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F);
        vsb = p6(6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01);
        vsy = p7(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40);

        // Reset held two edges with a beat offered.
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = v1a;
        b = v1b;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_y", {22'b0, y}, 64'd0);
        chk("rst_sig", {32'b0, sig}, 64'd0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_no_beat", {63'b0, out_valid}, 64'd0);
        tick();

        // Back-to-back beats, one per cycle, all four operations.
        send(2'd0, v1a, v1b, v1y);
        send(2'd1, v2a, v2b, v2y);
        send(2'd2, v3a, v3b, v3y);
        send(2'd3, v4a, v4b, v4y);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("stream_drain", exp_q.size(), 64'd0);
        tick();

        // Backpressure: three beats offered, only two may be buffered.
        out_ready = 1'b0;
        acc0 = acc_cnt;
        fork
            begin
                send(2'd1, v2a, v2b, v2y);
                send(2'd2, v3a, v3b, v3y);
                send(2'd3, v4a, v4b, v4y);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
                y_hold = y;
                repeat (2) @(negedge clk);
                chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
                chk("bp_accepted_two", acc_cnt - acc0, 64'd2);
                chk("bp_y_stable", {22'b0, y}, {22'b0, y_hold});
                chk("bp_y_first", {22'b0, y}, {22'b0, v2y});
                tick();
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("bp_drain", exp_q.size(), 64'd0);
        tick();

        // Reset with two beats in flight: both must vanish.
        out_ready = 1'b0;
        send(2'd0, v1a, v1b, v1y);
        send(2'd1, v2a, v2b, v2y);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        tick();
        @(negedge clk);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_y", {22'b0, y}, 64'd0);
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // First beat after reset: latency of two edges from the accepting edge.
        op = 2'd0;
        a = vsa;
        b = vsb;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {63'b0, in_ready}, 64'd1);
        if (in_ready) exp_q.push_back(vsy);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_valid", {63'b0, out_valid}, 64'd1);
        tick();

        // Signature: clear, then fold single beats.
        sig_clr = 1'b1;
        tick();
        sig_clr = 1'b0;
        @(negedge clk);
        chk("sig_cleared", {32'b0, sig}, 64'd0);
        tick();
        send(2'd0, vsa, vsb, vsy);
        repeat (3) @(negedge clk);
        chk("sig_one_beat", {32'b0, sig}, 64'h40);
        tick();
        send(2'd0, v1a, v1b, v1y);
        repeat (3) @(negedge clk);
        chk("sig_two_beats", {32'b0, sig}, 64'hD40);
        tick();

        // Clear in the same cycle as a handshake wins and drops that beat's contribution.
        out_ready = 1'b0;
        send(2'd0, vsa, vsb, vsy);
        repeat (2) @(negedge clk);
        chk("sigclr_pending", {63'b0, out_valid}, 64'd1);
        tick();
        out_ready = 1'b1;
        sig_clr = 1'b1;
        tick();
        sig_clr = 1'b0;
        @(negedge clk);
        chk("sigclr_priority", {32'b0, sig}, 64'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("final_drain", exp_q.size(), 64'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/expr_pipe_unit.md
EXPR_PIPE_UNIT -- requirements
Module: expr_pipe_unit

Interface
REQ-001 SHALL provide parameter W, default 6: operand width per lane.
REQ-002 SHALL provide parameter LANES, default 6: number of independent operand lanes.
REQ-003 SHALL provide parameter SMASK, LANES bits wide, default 6'b111000: bit i=1 makes lane i signed, 0 makes it unsigned.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: input beat offered.
REQ-007 SHALL have port in_ready, output, 1: input beat accepted when high with in_valid.
REQ-008 SHALL have port op, input, 2: operation code, sampled with the beat.
REQ-009 SHALL have port a, input, LANES*W: lane i occupies bits [i*W +: W].
REQ-010 SHALL have port b, input, LANES*W: same lane layout as a.
REQ-011 SHALL have port out_valid, output, 1: result beat available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port y, output, LANES*(W+1): lane i result at bits [i*(W+1) +: W+1].
REQ-014 SHALL have port sig_clr, input, 1: synchronous clear of the signature.
REQ-015 SHALL have port sig, output, 32: running result signature.

Function
REQ-016 SHALL extend each lane operand to W+1 bits: sign-extend if SMASK[i]=1, zero-extend otherwise (ea, eb).
REQ-017 SHALL compute per lane: op=0 ea+eb; op=1 ea-eb; op=2 {W'b0, ea<eb}, comparison signed for signed lanes and unsigned otherwise; op=3 ea^~eb. All results truncated to W+1 bits.
REQ-018 SHALL implement two register stages: S1 captures a, b and op on accept; S2 captures the computed y from S1.
REQ-019 SHALL present out_valid exactly 2 cycles after the accepting edge when out_ready has been held high; throughput SHALL be 1 beat per cycle.
REQ-020 SHALL advance S2 when S2 is empty or out_valid&&out_ready; SHALL advance S1 into S2 whenever S2 advances.
REQ-021 SHALL drive in_ready = rst_n && (!S1_valid || S1 advances), combinationally.
REQ-022 SHALL hold y and out_valid stable while out_valid=1 and out_ready=0; no beat SHALL be lost, duplicated or reordered.
REQ-023 SHALL buffer at most 2 beats, one in S1 and one in S2; with out_ready low, in_ready SHALL drop after the second beat is accepted.
REQ-024 SHALL update sig on each output handshake: sig <= {sig[30:0],sig[31]} ^ F. F is the XOR of y zero-extended to a multiple of 32 bits and split into 32-bit chunks.
REQ-025 SHALL set sig to 0 when sig_clr=1; sig_clr SHALL take priority over a same-cycle handshake, and that handshake's contribution SHALL be discarded.
REQ-026 SHALL keep y unchanged between beats; it SHALL never be recomputed from live inputs.

Reset
REQ-027 SHALL, while rst_n=0 at an edge, clear S1_valid, S2_valid, out_valid to 0, y to 0 and sig to 0.
REQ-028 SHALL hold in_ready=0 while rst_n=0.
REQ-029 SHALL discard beats in flight when reset is asserted mid-operation; the first beat after reset SHALL see latency 2.

Verification
REQ-030 SHALL cover reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, y=0, sig=0, and no beat emerges after release.
REQ-031 SHALL cover add: op=0, lane0 a=6'h3F, b=6'h01 -> lane0 y=7'h40; lane3 a=6'h3F (-1), b=1 -> lane3 y=7'h00; out_valid asserts exactly 2 cycles after accept.
REQ-032 SHALL cover subtract: op=1, lane5 a=6'h20 (-32), b=1 -> lane5 y=7'h5F; lane1 a=0, b=1 -> lane1 y=7'h7F.
REQ-033 SHALL cover compare: op=2, lane4 a=6'h3F, b=1 -> lane4 y=7'h01 (signed, -1<1); lane0 a=6'h3F, b=1 -> lane0 y=7'h00 (unsigned).
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles while offering 3 beats -> 2 accepted then in_ready=0, y stable; on out_ready=1 all 3 beats emerge in order.
REQ-035 SHALL cover the signature: sig_clr pulse, then one handshake with y lane0=7'h40 and other lanes 0 -> sig=32'h00000040; sig_clr in the same cycle as a handshake -> sig=0.
